// File: rtl/cfg_write_arbiter.sv
// cfg_write_arbiter: round-robin arbiter that serialises two requesters onto
// the shared configuration memory write port. Each grant produces a single
// mem_wren pulse with a matching one-cycle ack, followed by GUARD idle cycles.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | sampling req; grants on any set bit, ties go to != last_id
// ST_WRITE | single cycle, mem_wren and ack[last_id] high
// ST_GUARD | GUARD dead cycles after a write, req ignored
module cfg_write_arbiter #(
    parameter int DW    = 35,
    parameter int GUARD = 1
) (
    input  logic          clk,
    input  logic          arst,
    input  logic [1:0]    req,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic [1:0]    ack,
    output logic          mem_wren,
    output logic [DW-1:0] mem_din,
    output logic          busy,
    output logic          last_id
);

    localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [1:0]    ack_q, ack_d;
    logic          mem_wren_q, mem_wren_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic          busy_q, busy_d;
    logic          last_id_q, last_id_d;
    logic          gnt;

    // Next-state and registered-output computation; outputs are produced one
    // edge ahead so every port comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        gcnt_d     = gcnt_q;
        ack_d      = 2'b00;
        mem_wren_d = 1'b0;
        mem_din_d  = mem_din_q;
        busy_d     = busy_q;
        last_id_d  = last_id_q;
        gnt        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (req != 2'b00) begin
                    // On a tie the requester not served last time wins.
                    if (req == 2'b11) gnt = ~last_id_q;
                    else              gnt = req[1];
                    state_d    = ST_WRITE;
                    ack_d      = gnt ? 2'b10 : 2'b01;
                    mem_wren_d = 1'b1;
                    mem_din_d  = gnt ? wdata1 : wdata0;
                    last_id_d  = gnt;
                    busy_d     = 1'b1;
                end
            end
            ST_WRITE: begin
                if (GUARD > 0) begin
                    state_d = ST_GUARD;
                    gcnt_d  = GW'(GUARD);
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
            ST_GUARD: begin
                if (gcnt_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                    gcnt_d  = '0;
                    busy_d  = 1'b0;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gcnt_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; last_id resets to 1 so requester 0 wins
    // the first tie.
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q    <= ST_IDLE;
            gcnt_q     <= '0;
            ack_q      <= 2'b00;
            mem_wren_q <= 1'b0;
            mem_din_q  <= '0;
            busy_q     <= 1'b0;
            last_id_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            gcnt_q     <= gcnt_d;
            ack_q      <= ack_d;
            mem_wren_q <= mem_wren_d;
            mem_din_q  <= mem_din_d;
            busy_q     <= busy_d;
            last_id_q  <= last_id_d;
        end
    end

    assign ack      = ack_q;
    assign mem_wren = mem_wren_q;
    assign mem_din  = mem_din_q;
    assign busy     = busy_q;
    assign last_id  = last_id_q;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// Directed bench for cfg_write_arbiter: a GUARD=1 instance driven by a
// vector table plus hand sequences, and a GUARD=0 instance for throughput.
module tb_cfg_write_arbiter;

    localparam int DW = 35;
    localparam logic [DW-1:0] WA = 35'h1_2345_6789;
    localparam logic [DW-1:0] WB = 35'h0_ABCD_EF01;

    logic          clk = 1'b0;
    logic          arst;
    logic [1:0]    req, req_g0;
    logic [DW-1:0] wdata0, wdata1;
    logic [1:0]    ack, ack_g0;
    logic          mem_wren, mem_wren_g0;
    logic [DW-1:0] mem_din, mem_din_g0;
    logic          busy, busy_g0;
    logic          last_id, last_id_g0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cfg_write_arbiter #(.DW(DW), .GUARD(1)) dut (
        .clk(clk), .arst(arst), .req(req), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack), .mem_wren(mem_wren), .mem_din(mem_din), .busy(busy),
        .last_id(last_id)
    );

    cfg_write_arbiter #(.DW(DW), .GUARD(0)) dut_g0 (
        .clk(clk), .arst(arst), .req(req_g0), .wdata0(wdata0), .wdata1(wdata1),
        .ack(ack_g0), .mem_wren(mem_wren_g0), .mem_din(mem_din_g0), .busy(busy_g0),
        .last_id(last_id_g0)
    );

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    ack;
        logic          wren;
        logic [DW-1:0] din;
        logic          busy;
        logic          last;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] a,
                                input logic w, input logic [DW-1:0] d,
                                input logic b, input logic l);
        vec_t v;
        v.req = r; v.ack = a; v.wren = w; v.din = d; v.busy = b; v.last = l;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [1:0] r, input logic [1:0] r_g0);
        arst   = 1'b0;
        req    = r;
        req_g0 = r_g0;
        @(negedge clk);
        @(negedge clk);
        arst = 1'b1;
    endtask

    initial begin
        logic [1:0] exp_ack;
        bit         found;

        wdata0 = WA;
        wdata1 = WB;
        arst   = 1'b0;
        req    = 2'b00;
        req_g0 = 2'b00;

        // Vectors: inputs applied, expected outputs after the next edge.
        tbl[0]  = mk(2'b01, 2'b01, 1'b1, WA, 1'b1, 1'b0);
        tbl[1]  = mk(2'b00, 2'b00, 1'b0, WA, 1'b1, 1'b0);
        tbl[2]  = mk(2'b00, 2'b00, 1'b0, WA, 1'b0, 1'b0);
        tbl[3]  = mk(2'b00, 2'b00, 1'b0, WA, 1'b0, 1'b0);
        tbl[4]  = mk(2'b11, 2'b10, 1'b1, WB, 1'b1, 1'b1);
        tbl[5]  = mk(2'b01, 2'b00, 1'b0, WB, 1'b1, 1'b1);
        tbl[6]  = mk(2'b01, 2'b00, 1'b0, WB, 1'b0, 1'b1);
        tbl[7]  = mk(2'b01, 2'b01, 1'b1, WA, 1'b1, 1'b0);
        tbl[8]  = mk(2'b10, 2'b00, 1'b0, WA, 1'b1, 1'b0);
        tbl[9]  = mk(2'b10, 2'b00, 1'b0, WA, 1'b0, 1'b0);
        tbl[10] = mk(2'b10, 2'b10, 1'b1, WB, 1'b1, 1'b1);
        tbl[11] = mk(2'b00, 2'b00, 1'b0, WB, 1'b1, 1'b1);
        tbl[12] = mk(2'b00, 2'b00, 1'b0, WB, 1'b0, 1'b1);

        // Reset values while arst is held low.
        #12;
        chk("rst_ack", 64'(ack), 64'(2'b00));
        chk("rst_wren", 64'(mem_wren), 64'd0);
        chk("rst_din", 64'(mem_din), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_last_id", 64'(last_id), 64'd1);

        // Table-driven vectors.
        do_reset(2'b00, 2'b00);
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            tick();
            chk($sformatf("v%0d_ack", i), 64'(ack), 64'(tbl[i].ack));
            chk($sformatf("v%0d_wren", i), 64'(mem_wren), 64'(tbl[i].wren));
            chk($sformatf("v%0d_din", i), 64'(mem_din), 64'(tbl[i].din));
            chk($sformatf("v%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
            chk($sformatf("v%0d_last", i), 64'(last_id), 64'(tbl[i].last));
        end

        // Both requesters held from reset: grants alternate every 3 cycles.
        do_reset(2'b11, 2'b00);
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_ack = (n % 3 == 1) ? (((n / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            chk($sformatf("alt_ack_c%0d", n), 64'(ack), 64'(exp_ack));
            chk($sformatf("alt_wren_c%0d", n), 64'(mem_wren), 64'(exp_ack != 2'b00));
            if (exp_ack != 2'b00)
                chk($sformatf("alt_din_c%0d", n), 64'(mem_din),
                    64'((exp_ack == 2'b01) ? WA : WB));
        end

        // req[1] raised during the guard of a requester-0 write.
        do_reset(2'b01, 2'b00);
        tick();
        chk("late_first_ack", 64'(ack), 64'(2'b01));
        req = 2'b00;
        tick();
        chk("late_guard_busy", 64'(busy), 64'd1);
        req   = 2'b10;
        found = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            tick();
            if (!found && ack != 2'b00) begin
                found = 1'b1;
                chk("late_grant_cycle", 64'(c), 64'd4);
                chk("late_ack", 64'(ack), 64'(2'b10));
                chk("late_din", 64'(mem_din), 64'(WB));
                req = 2'b00;
            end
        end
        if (!found) chk("late_grant_timeout", 64'd0, 64'd1);

        // GUARD=0 instance, requester 1 held: a write every 2 cycles.
        do_reset(2'b00, 2'b10);
        for (int n = 1; n <= 10; n++) begin
            tick();
            chk($sformatf("g0_wren_c%0d", n), 64'(mem_wren_g0), 64'(n % 2));
            chk($sformatf("g0_ack_c%0d", n), 64'(ack_g0), 64'((n % 2 == 1) ? 2'b10 : 2'b00));
        end
        chk("g0_last_id", 64'(last_id_g0), 64'd1);
        req_g0 = 2'b00;

        // Reset asserted during the WRITE cycle.
        do_reset(2'b01, 2'b00);
        tick();
        chk("mid_pre_wren", 64'(mem_wren), 64'd1);
        arst = 1'b0;
        #1;
        chk("mid_wren", 64'(mem_wren), 64'd0);
        chk("mid_ack", 64'(ack), 64'(2'b00));
        chk("mid_busy", 64'(busy), 64'd0);
        #1;
        arst = 1'b1;
        tick();
        chk("mid_regrant_ack", 64'(ack), 64'(2'b01));
        chk("mid_regrant_wren", 64'(mem_wren), 64'd1);
        chk("mid_regrant_din", 64'(mem_din), 64'(WA));
        req = 2'b00;

        // Idle for 20 cycles after the write: no pulses, word retained.
        wdata0 = 35'h7_0000_0001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk($sformatf("idle_wren_c%0d", n), 64'(mem_wren), 64'd0);
            chk($sformatf("idle_ack_c%0d", n), 64'(ack), 64'(2'b00));
            chk($sformatf("idle_din_c%0d", n), 64'(mem_din), 64'(WA));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfg_write_arbiter.md
# cfg_write_arbiter

Two-requester, round-robin arbiter for the shared 35-bit configuration memory write port of the smart home system.

- Requester 0 is the user-driven control unit path.
- Requester 1 is the scene/scheduler path.
- The block serialises their writes into single-cycle `mem_wren` pulses and returns a per-requester acknowledge.
- It sits between the two requesters and the memory unit, replacing a direct `write_en`/`configout` connection.

## Interface

Parameters:
- `DW`, default 35: width of a configuration word.
- `GUARD`, default 1: idle cycles inserted after every write before the next grant. 0 is legal.

Ports:
- `clk`  input  1  clock, posedge.
- `arst`  input  1  asynchronous reset, active-low.
- `req`  input  2  write request, bit i from requester i. Level, held until ack.
- `wdata0`  input  DW  configuration word from requester 0. Stable while `req[0]` is high.
- `wdata1`  input  DW  configuration word from requester 1. Stable while `req[1]` is high.
- `ack`  output  2  one-cycle acknowledge to the served requester.
- `mem_wren`  output  1  write enable to the memory unit.
- `mem_din`  output  DW  word to the memory unit.
- `busy`  output  1  high in WRITE and GUARD states.
- `last_id`  output  1  index of the most recently served requester.

## Operation

- All outputs are registered.
- Reset (`arst`=0) forces, asynchronously:
  - `ack`=0, `mem_wren`=0, `mem_din`=0, `busy`=0, `last_id`=1.
  - `last_id`=1 means requester 0 wins the first tie.
  - State IDLE, guard counter 0.
- States:
  - IDLE: sample `req` on each rising edge.
    - If no bit is set, stay in IDLE.
    - If exactly one bit is set, grant that requester.
    - If both bits are set, grant the requester != `last_id`.
    - On grant: capture `wdata<i>` into `mem_din`, set `last_id`=i, go to WRITE.
  - WRITE, exactly one cycle: `mem_wren`=1, `ack[i]`=1, `busy`=1.
    - Next state is GUARD if `GUARD`>0, else IDLE.
  - GUARD, exactly `GUARD` cycles: `busy`=1, `mem_wren`=0, `ack`=0, `req` ignored. Then go to IDLE.
- `mem_din` holds the last written word until the next grant. It is not cleared after the write.
- A requester must drop `req[i]` on the edge that ends its ack cycle.
  - If `req[i]` is still high when IDLE next samples it, that is a new request and the word is written again.
- A request raised during WRITE or GUARD waits; it is not lost.
- Guard counter width is max(1, clog2(`GUARD`+1)). It loads `GUARD` on entry to GUARD and counts down to 1.
- Never both `ack` bits high at once. `ack` is high only when `mem_wren` is high.

## Timing

- Grant latency: `req` seen high at IDLE edge k gives `mem_wren`/`ack` high during cycle k..k+1. The memory captures the word at edge k+1.
- Throughput: at most one write per `GUARD`+2 cycles. The next IDLE sample is edge k+2+`GUARD`.
- With both requesters continuously requesting, grants strictly alternate 0,1,0,1... Neither requester can starve.
- A single requester held continuously gets one write per `GUARD`+2 cycles. `last_id` still updates.
- Reset asserted mid-WRITE:
  - `mem_wren` and `ack` drop immediately.
  - The write is not guaranteed and no ack is delivered; the requester must retry after reset.
- Reset asserted mid-GUARD: the guard is abandoned. The first sample after reset release is at the first rising edge.
- `req` bits are assumed synchronous to `clk`. There is no internal synchroniser.

## Test plan

- Reset, then `req`=01 with `wdata0`=0x1_2345_6789 held at edge 1:
  - Cycle 1: `mem_wren`=1, `ack`=01, `mem_din`=0x1_2345_6789, `last_id`=0.
  - Cycle 2 (`GUARD`=1): `busy`=1, `mem_wren`=0.
- Both `req` high from reset, `GUARD`=1, held 12 cycles:
  - `ack` sequence 01,10,01,10 on cycles 1,4,7,10.
  - `mem_din` alternates `wdata0`/`wdata1`.
- `req[1]` raised during GUARD of a requester-0 write:
  - Granted at the first IDLE edge.
  - `ack`=10 exactly one cycle later. No write is dropped.
- `GUARD`=0, `req`=10 held continuously:
  - `mem_wren` pulses every 2 cycles.
  - `ack[0]` never asserted.
- `arst` low during the WRITE cycle:
  - `mem_wren`, `ack`, `busy` go to 0 without a clock edge.
  - After release with `req`=01, a fresh grant occurs at the first edge.
- Idle bench, `req`=00 for 20 cycles after a write:
  - `mem_wren`=0 and `ack`=00 throughout.
  - `mem_din` retains the last word.
